// File: rtl/arp_lookup_ctrl_pkg.sv
// Shared types and widths for the ARP lookup controller that fronts the network slice.
// Reply and response layouts are packed so they map bit-exactly onto the slice ports.
package arp_lookup_ctrl_pkg;

    localparam int ARP_REQ_BITS = 32;
    localparam int ARP_REP_BITS = 56;
    localparam int ARP_RSP_BITS = 82;

    typedef enum logic [1:0] {
        ARP_HIT     = 2'b00,
        ARP_MISS    = 2'b01,
        ARP_TIMEOUT = 2'b10
    } arp_status_t;

    typedef struct packed {
        logic [6:0]  rsvd;
        logic        hit;
        logic [47:0] mac;
    } arp_rep_t;

    typedef struct packed {
        arp_status_t status;
        logic [47:0] mac;
        logic [31:0] ip;
    } arp_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_RSP  = 3'd4
    } arp_state_t;

    function automatic arp_rsp_t make_rsp(input arp_status_t status,
                                          input logic [47:0] mac,
                                          input logic [31:0] ip);
        arp_rsp_t r;
        r.status = status;
        r.mac    = mac;
        r.ip     = ip;
        return r;
    endfunction

endpackage

// File: rtl/arp_lookup_ctrl_if.sv
// Handshake channels of the ARP lookup controller: command, slice request/reply, response.
// The master modport is the controller; the slave modport is its surroundings.
interface arp_lookup_ctrl_if;
    import arp_lookup_ctrl_pkg::*;

    logic                    s_cmd_valid;
    logic                    s_cmd_ready;
    logic [31:0]             s_cmd_ip;
    logic                    m_arp_req_valid;
    logic                    m_arp_req_ready;
    logic [ARP_REQ_BITS-1:0] m_arp_req_data;
    logic                    s_arp_rep_valid;
    logic                    s_arp_rep_ready;
    logic [ARP_REP_BITS-1:0] s_arp_rep_data;
    logic                    m_rsp_valid;
    logic                    m_rsp_ready;
    logic [ARP_RSP_BITS-1:0] m_rsp_data;

    modport master (
        input  s_cmd_valid, s_cmd_ip, m_arp_req_ready, s_arp_rep_valid, s_arp_rep_data, m_rsp_ready,
        output s_cmd_ready, m_arp_req_valid, m_arp_req_data, s_arp_rep_ready, m_rsp_valid, m_rsp_data
    );

    modport slave (
        output s_cmd_valid, s_cmd_ip, m_arp_req_ready, s_arp_rep_valid, s_arp_rep_data, m_rsp_ready,
        input  s_cmd_ready, m_arp_req_valid, m_arp_req_data, s_arp_rep_ready, m_rsp_valid, m_rsp_data
    );

endinterface

// File: rtl/arp_lookup_ctrl_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping; clear has priority.
module arp_lookup_ctrl_sat_counter #(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                inc,
    output logic [CNT_BITS-1:0] cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Count register with synchronous clear and saturation
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/arp_lookup_ctrl.sv
// ARP resolution controller: one lookup in flight, retries after a miss reply,
// reports TIMEOUT when the slice stays silent, and keeps saturating statistics.
module arp_lookup_ctrl
    import arp_lookup_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_GAP   = 256,
    parameter int CNT_BITS    = 32
) (
    input  logic                aclk,
    input  logic                areset,
    arp_lookup_ctrl_if.master   bus,
    output logic [CNT_BITS-1:0] o_cnt_lookup,
    output logic [CNT_BITS-1:0] o_cnt_miss,
    output logic [CNT_BITS-1:0] o_cnt_timeout,
    output logic [CNT_BITS-1:0] o_cnt_stale
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    arp_state_t    state_r, state_nxt;
    logic [31:0]   ip_r, ip_nxt;
    logic [TW-1:0] timer_r, timer_nxt;
    logic [GW-1:0] gap_r, gap_nxt;
    logic [RW-1:0] retry_r, retry_nxt;
    arp_rsp_t      rsp_r, rsp_nxt;
    logic          cmd_ready_r, req_valid_r, rep_ready_r, rsp_valid_r;
    logic          cmd_hs_s, req_hs_s, rep_hs_s, rsp_hs_s;
    logic          inc_miss_s, inc_timeout_s, inc_stale_s;
    arp_rep_t      rep_s;
    logic          rsvd_unused_s;

    assign rep_s         = arp_rep_t'(bus.s_arp_rep_data);
    assign rsvd_unused_s = ^rep_s.rsvd;
    assign cmd_hs_s      = bus.s_cmd_valid & cmd_ready_r;
    assign req_hs_s      = req_valid_r & bus.m_arp_req_ready;
    assign rep_hs_s      = bus.s_arp_rep_valid & rep_ready_r;
    assign rsp_hs_s      = rsp_valid_r & bus.m_rsp_ready;
    assign inc_stale_s   = rep_hs_s & (state_r != ST_WAIT);

    assign bus.s_cmd_ready     = cmd_ready_r;
    assign bus.m_arp_req_valid = req_valid_r;
    assign bus.m_arp_req_data  = ip_r;
    assign bus.s_arp_rep_ready = rep_ready_r;
    assign bus.m_rsp_valid     = rsp_valid_r;
    assign bus.m_rsp_data      = rsp_r;

    // Next-state, timer, retry and response computation
    always_comb begin
        state_nxt     = state_r;
        ip_nxt        = ip_r;
        timer_nxt     = timer_r;
        gap_nxt       = gap_r;
        retry_nxt     = retry_r;
        rsp_nxt       = rsp_r;
        inc_miss_s    = 1'b0;
        inc_timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) begin
                    ip_nxt    = bus.s_cmd_ip;
                    retry_nxt = '0;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (req_hs_s) begin
                    timer_nxt = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A reply arriving on the last timer cycle still beats the timeout
                if (rep_hs_s) begin
                    if (rep_s.hit) begin
                        rsp_nxt   = make_rsp(ARP_HIT, rep_s.mac, ip_r);
                        state_nxt = ST_RSP;
                    end else if (retry_r < RETRY_LIMIT) begin
                        retry_nxt = retry_r + RW'(1);
                        gap_nxt   = '0;
                        state_nxt = ST_GAP;
                    end else begin
                        rsp_nxt    = make_rsp(ARP_MISS, 48'h0, ip_r);
                        inc_miss_s = 1'b1;
                        state_nxt  = ST_RSP;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    rsp_nxt       = make_rsp(ARP_TIMEOUT, 48'h0, ip_r);
                    inc_timeout_s = 1'b1;
                    state_nxt     = ST_RSP;
                end else begin
                    timer_nxt = timer_r + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nxt = ST_REQ;
                end else begin
                    gap_nxt = gap_r + GW'(1);
                end
            end
            ST_RSP: begin
                if (rsp_hs_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_RSP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            ip_r        <= 32'h0;
            timer_r     <= '0;
            gap_r       <= '0;
            retry_r     <= '0;
            rsp_r       <= '0;
            cmd_ready_r <= 1'b0;
            req_valid_r <= 1'b0;
            rep_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            ip_r        <= ip_nxt;
            timer_r     <= timer_nxt;
            gap_r       <= gap_nxt;
            retry_r     <= retry_nxt;
            rsp_r       <= rsp_nxt;
            cmd_ready_r <= (state_nxt == ST_IDLE);
            req_valid_r <= (state_nxt == ST_REQ);
            rep_ready_r <= 1'b1;
            rsp_valid_r <= (state_nxt == ST_RSP);
        end
    end

    arp_lookup_ctrl_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_lookup (
        .clk(aclk), .clear(areset), .inc(cmd_hs_s), .cnt(o_cnt_lookup)
    );
    arp_lookup_ctrl_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_miss (
        .clk(aclk), .clear(areset), .inc(inc_miss_s), .cnt(o_cnt_miss)
    );
    arp_lookup_ctrl_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_timeout (
        .clk(aclk), .clear(areset), .inc(inc_timeout_s), .cnt(o_cnt_timeout)
    );
    arp_lookup_ctrl_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt_stale (
        .clk(aclk), .clear(areset), .inc(inc_stale_s), .cnt(o_cnt_stale)
    );

endmodule

// File: tb/tb_arp_lookup_ctrl.sv
// Bench for arp_lookup_ctrl: a scripted slice responder, a response scoreboard and a
// list-of-attempts reference model; small timing parameters keep boundaries reachable.
module tb_arp_lookup_ctrl;
    import arp_lookup_ctrl_pkg::*;

    localparam int T   = 64;
    localparam int G   = 8;
    localparam int R   = 3;
    localparam int CB  = 4;
    localparam int SAT = (1 << CB) - 1;
    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_NONE = 2;

    typedef struct { int kind; int delay; logic [47:0] mac; } attempt_t;
    typedef struct { logic [81:0] rsp; int nreq; bit timeout; } exp_t;

    logic aclk = 1'b0;
    logic areset;
    logic [CB-1:0] cnt_lookup, cnt_miss, cnt_timeout, cnt_stale;
    arp_lookup_ctrl_if bus();

    arp_lookup_ctrl #(.TIMEOUT_CYC(T), .MAX_RETRY(R), .RETRY_GAP(G), .CNT_BITS(CB)) dut (
        .aclk(aclk), .areset(areset), .bus(bus),
        .o_cnt_lookup(cnt_lookup), .o_cnt_miss(cnt_miss),
        .o_cnt_timeout(cnt_timeout), .o_cnt_stale(cnt_stale)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    attempt_t cur_q[$];
    attempt_t script_q[$];
    exp_t exp_q[$];
    int n_lookup = 0, n_miss = 0, n_timeout = 0, n_stale = 0;
    int issued = 0, rsp_count = 0;
    int req_in_cmd = 0, cmd_hs_cyc = 0, last_hs_cyc = 0, last_rep_cyc = 0;
    logic [31:0] cur_ip = 32'h0;
    bit hold_req = 1'b0, hold_rsp = 1'b0, inject_stray = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the attempts; hit ends it, silence times out, R+1 misses give MISS
    function automatic exp_t model(input logic [31:0] ip);
        exp_t e;
        e.rsp = '0; e.nreq = 0; e.timeout = 1'b0;
        foreach (cur_q[i]) begin
            e.nreq++;
            if (cur_q[i].kind == K_HIT) begin
                e.rsp = {2'b00, cur_q[i].mac, ip};
                return e;
            end
            if (cur_q[i].kind == K_NONE) begin
                e.rsp = {2'b10, 48'h0, ip};
                e.timeout = 1'b1;
                return e;
            end
            if (e.nreq == R + 1) begin
                e.rsp = {2'b01, 48'h0, ip};
                return e;
            end
        end
        return e;
    endfunction

    function automatic int sat(input int n);
        return (n > SAT) ? SAT : n;
    endfunction

    task automatic add(input int kind, input int delay, input logic [47:0] mac);
        attempt_t a;
        a.kind = kind; a.delay = delay; a.mac = mac;
        cur_q.push_back(a);
    endtask

    task automatic gen_random();
        cur_q.delete();
        for (int a = 0; a <= R; a++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = T - 1;
                default: d = $urandom_range(0, 20);
            endcase
            add((r < 4) ? K_HIT : ((r < 8) ? K_MISS : K_NONE), d, 48'({$urandom(), $urandom()}));
            if (cur_q[a].kind != K_MISS) break;
        end
    endtask

    task automatic issue(input logic [31:0] ip);
        exp_t e;
        int waited;
        e = model(ip);
        for (int i = 0; i < e.nreq; i++) script_q.push_back(cur_q[i]);
        cur_q.delete();
        exp_q.push_back(e);
        n_lookup++;
        if (e.rsp[81:80] == 2'b01) n_miss++;
        if (e.timeout) n_timeout++;
        bus.s_cmd_ip = ip;
        bus.s_cmd_valid = 1'b1;
        waited = 0;
        while (!bus.s_cmd_ready && waited < 3000) begin
            @(posedge aclk); #1;
            waited++;
        end
        check("cmd_accepted", bus.s_cmd_ready, 1'b1);
        cur_ip = ip;
        req_in_cmd = 0;
        cmd_hs_cyc = cyc;
        issued++;
        @(posedge aclk); #1;
        bus.s_cmd_valid = 1'b0;
        bus.s_cmd_ip = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (rsp_count != issued && n < 4000) begin
            @(posedge aclk); #1;
            n++;
        end
        check("rsp_count", rsp_count, issued);
    endtask

    task automatic check_counters();
        check("cnt_lookup", cnt_lookup, sat(n_lookup));
        check("cnt_miss", cnt_miss, sat(n_miss));
        check("cnt_timeout", cnt_timeout, sat(n_timeout));
        check("cnt_stale", cnt_stale, sat(n_stale));
    endtask

    task automatic check_reset_values();
        check("rst_cmd_ready", bus.s_cmd_ready, 1'b0);
        check("rst_req_valid", bus.m_arp_req_valid, 1'b0);
        check("rst_req_data", bus.m_arp_req_data, 32'h0);
        check("rst_rep_ready", bus.s_arp_rep_ready, 1'b0);
        check("rst_rsp_valid", bus.m_rsp_valid, 1'b0);
        check("rst_rsp_data", bus.m_rsp_data, 82'h0);
        check("rst_counters", {cnt_lookup, cnt_miss, cnt_timeout, cnt_stale}, 16'h0);
    endtask

    // Slice model: accepts requests with random backpressure and plays back scripted replies
    initial begin : responder
        attempt_t cur_att;
        bit pend, prev_valid, prev_hs;
        int rep_at;
        logic [31:0] prev_data;
        pend = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; rep_at = 0; prev_data = 32'h0;
        cur_att.kind = K_NONE; cur_att.delay = 0; cur_att.mac = 48'h0;
        bus.m_arp_req_ready = 1'b0;
        bus.s_arp_rep_valid = 1'b0;
        bus.s_arp_rep_data  = 56'h0;
        forever begin
            @(posedge aclk); #1;
            bus.s_arp_rep_valid = 1'b0;
            bus.m_arp_req_ready = 1'b0;
            if (areset) begin
                pend = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0;
                req_in_cmd = 0;
            end else begin
                if (pend && cyc == rep_at) begin
                    check("rep_ready", bus.s_arp_rep_ready, 1'b1);
                    bus.s_arp_rep_valid = 1'b1;
                    bus.s_arp_rep_data = {7'($urandom), (cur_att.kind == K_HIT), cur_att.mac};
                    pend = 1'b0;
                    last_rep_cyc = cyc;
                end else if (inject_stray) begin
                    bus.s_arp_rep_valid = 1'b1;
                    bus.s_arp_rep_data = {8'($urandom) | 8'h01, 48'({$urandom(), $urandom()})};
                    inject_stray = 1'b0;
                end
                bus.m_arp_req_ready = hold_req ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (bus.m_arp_req_valid) begin
                    if (!prev_valid) begin
                        if (req_in_cmd == 0) check("req_latency", cyc - cmd_hs_cyc, 1);
                        else check("retry_gap", cyc - last_rep_cyc, G + 1);
                    end else if (!prev_hs) begin
                        check("req_hold", bus.m_arp_req_data, prev_data);
                    end
                    check("req_ip", bus.m_arp_req_data, cur_ip);
                    if (bus.m_arp_req_ready) begin
                        req_in_cmd++;
                        last_hs_cyc = cyc;
                        if (script_q.size() == 0) begin
                            errors++; checks++;
                            $display("FAIL unexpected_req: got request for %h expected none", bus.m_arp_req_data);
                        end else begin
                            cur_att = script_q.pop_front();
                            if (cur_att.kind != K_NONE) begin
                                pend = 1'b1;
                                rep_at = cyc + 1 + cur_att.delay;
                            end
                        end
                    end
                end
                prev_valid = bus.m_arp_req_valid;
                prev_hs = bus.m_arp_req_valid & bus.m_arp_req_ready;
                prev_data = bus.m_arp_req_data;
            end
        end
    end

    // Scoreboard monitor: consumes responses and compares against the expectation queue
    initial begin : monitor
        exp_t e;
        bit prev_valid, prev_hs;
        logic [81:0] prev_data;
        int want;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
        bus.m_rsp_ready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            bus.m_rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (prev_hs && !areset) check("cmd_ready_after_rsp", bus.s_cmd_ready, 1'b1);
            if (bus.m_rsp_valid) begin
                if (!prev_valid && exp_q.size() > 0) begin
                    want = exp_q[0].timeout ? (last_hs_cyc + T + 1) : (last_rep_cyc + 1);
                    check("rsp_latency", cyc, want);
                end else if (prev_valid && !prev_hs) begin
                    check("rsp_hold", bus.m_rsp_data, prev_data);
                end
                check("cmd_ready_busy", bus.s_cmd_ready, 1'b0);
                if (bus.m_rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_rsp: got %h expected no response", bus.m_rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", bus.m_rsp_data, e.rsp);
                        check("req_count", req_in_cmd, e.nreq);
                        rsp_count++;
                    end
                end
            end
            prev_valid = bus.m_rsp_valid;
            prev_hs = bus.m_rsp_valid & bus.m_rsp_ready;
            prev_data = bus.m_rsp_data;
        end
    end

    initial begin : driver
        int n;
        areset = 1'b1;
        bus.s_cmd_valid = 1'b0;
        bus.s_cmd_ip = 32'h0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_values();
        areset = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        check("cmd_ready_out_of_reset", bus.s_cmd_ready, 1'b1);

        // plain hit, reply 10 cycles into WAIT
        add(K_HIT, 9, 48'h0011_2233_4455);
        issue(32'h0A00_0001);
        wait_done();
        check_counters();

        // all misses: R retries then MISS
        for (int i = 0; i <= R; i++) add(K_MISS, $urandom_range(0, 10), 48'hDEAD_BEEF_0000);
        issue(32'hC0A8_0101);
        wait_done();
        check_counters();

        // miss then hit
        add(K_MISS, 3, 48'h1);
        add(K_HIT, 5, 48'hA1B2_C3D4_E5F6);
        issue(32'h0A00_0002);
        wait_done();

        // silence -> timeout; then a hit on the very last WAIT cycle
        add(K_NONE, 0, 48'h0);
        issue(32'h0A00_0003);
        wait_done();
        add(K_HIT, T - 1, 48'h0102_0304_0506);
        issue(32'h0A00_0004);
        wait_done();
        check_counters();

        // backpressure on request and response channels
        hold_req = 1'b1;
        hold_rsp = 1'b1;
        add(K_HIT, 2, 48'hFEED_FACE_CAFE);
        issue(32'h0A00_0005);
        for (int i = 0; i < 20; i++) begin
            check("bp_req_valid", bus.m_arp_req_valid, 1'b1);
            check("bp_req_data", bus.m_arp_req_data, 32'h0A00_0005);
            check("bp_cmd_ready", bus.s_cmd_ready, 1'b0);
            @(posedge aclk); #1;
        end
        hold_req = 1'b0;
        n = 0;
        while (!bus.m_rsp_valid && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            check("bp_rsp_valid", bus.m_rsp_valid, 1'b1);
            check("bp_rsp_cmd_ready", bus.s_cmd_ready, 1'b0);
            @(posedge aclk); #1;
        end
        hold_rsp = 1'b0;
        wait_done();
        repeat (2) @(posedge aclk);
        #1;
        inject_stray = 1'b1;
        n_stale++;
        repeat (3) @(posedge aclk);
        #1;
        check_counters();

        // reset while waiting for a reply
        add(K_NONE, 0, 48'h0);
        issue(32'h0A00_0006);
        repeat (10) @(posedge aclk);
        #1;
        areset = 1'b1;
        exp_q.delete();
        script_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_values();
        areset = 1'b0;
        n_lookup = 0; n_miss = 0; n_timeout = 0; n_stale = 0;
        issued = rsp_count;
        repeat (2) @(posedge aclk);
        #1;
        add(K_HIT, 4, 48'h7777_8888_9999);
        issue(32'h0A00_0007);
        wait_done();
        check_counters();

        // random lookups, enough to saturate the lookup counter
        for (int k = 0; k < 30; k++) begin
            gen_random();
            issue($urandom);
            wait_done();
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) @(posedge aclk);
                #1;
                inject_stray = 1'b1;
                n_stale++;
                repeat (2) @(posedge aclk);
                #1;
            end
            check_counters();
        end
        check("exp_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
